// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD-card SPI-mode command sequencer.
//   state_t  - top-level sequencer states
//   xfer_t   - sub-state of the byte-transfer primitive
//   Frame constants and the fixed CRC table used when CRC7 generation is off.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    FRAME,
    POLL,
    DATA,
    POST,
    RESP
  } state_t;

  typedef enum logic {
    ISSUE,
    WAIT
  } xfer_t;

  localparam logic [7:0] FILL_BYTE      = 8'hFF;
  localparam logic [1:0] CMD_START_BITS = 2'b01;
  localparam logic [7:0] CRC_CMD0       = 8'h95;
  localparam logic [7:0] CRC_CMD8       = 8'h87;
  localparam logic [7:0] CRC_DEFAULT    = 8'h01;

  // Only CMD0 and CMD8 are checked by the card before CRC is enabled,
  // so every other command can carry a dummy CRC with the end bit set.
  function automatic logic [7:0] crc_lookup(input logic [5:0] idx);
    case (idx)
      6'd0:    return CRC_CMD0;
      6'd8:    return CRC_CMD8;
      default: return CRC_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: command request / response handshake between the SD
// init/read controller (master) and the command sequencer (slave).
//   cmd_valid/cmd_ready - request handshake, cmd_idx/cmd_arg/cmd_long payload
//   rsp_valid           - one-cycle response pulse
//   rsp_r1/rsp_data/rsp_timeout - response fields, held until next response
interface sd_cmd_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_long;
  logic        rsp_valid;
  logic [7:0]  rsp_r1;
  logic [31:0] rsp_data;
  logic        rsp_timeout;

  modport master (
    output cmd_valid, cmd_idx, cmd_arg, cmd_long,
    input  cmd_ready, rsp_valid, rsp_r1, rsp_data, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_arg, cmd_long,
    output cmd_ready, rsp_valid, rsp_r1, rsp_data, rsp_timeout
  );

endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: byte-wide CRC7 (x^7 + x^3 + 1, init 0), MSB first.
//   clk, reset_n - clock, async active-low reset
//   clr          - restart the CRC at zero (has priority over en)
//   en           - fold din into the running CRC
//   din          - byte to fold in
//   crc          - current CRC7 value
module sd_crc7 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [6:0] crc
);

  function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic [7:0] dd;
    logic       fb;
    r  = c;
    dd = d;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[6] ^ dd[7];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
      dd = {dd[6:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= '0;
    else if (clr)  crc <= '0;
    else if (en)   crc <= crc7_byte(crc, din);
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues one SD SPI-mode command through the byte-wide SPI
// engine: preamble byte, 6-byte frame, R1 polling, optional 4-byte R3/R7
// payload, Ncs trailer, then a one-cycle response on the handshake interface.
//   clk, reset_n            - clock, async active-low reset (aborts silently)
//   cmd                     - command/response handshake (slave side)
//   spi_start/spi_tx        - one-cycle byte request and byte to send
//   spi_rx/spi_done         - received byte, qualified by spi_done pulse
//   spi_busy                - engine busy; no request is made while high
//   sd_cs                   - card chip-select, active low, owned here
// Build option: define SD_CRC7_EN to generate the frame CRC7 on the fly;
// otherwise a fixed CRC table (CMD0/CMD8/dummy) is used.
module sd_cmd_sequencer #(
  parameter int unsigned NCR_MAX   = 8,
  parameter logic [7:0]  FILL_BYTE = sd_pkg::FILL_BYTE
) (
  input  logic                clk,
  input  logic                reset_n,
  sd_cmd_sequencer_if.slave   cmd,
  output logic                spi_start,
  output logic [7:0]          spi_tx,
  input  logic [7:0]          spi_rx,
  input  logic                spi_done,
  input  logic                spi_busy,
  output logic                sd_cs
);

  import sd_pkg::*;

  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

  state_t      state;
  xfer_t       phase;
  logic [2:0]  byte_cnt;
  logic [7:0]  poll_cnt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        long_q;
  logic [7:0]  r1_w;
  logic [31:0] data_w;
  logic        to_w;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_r1_q;
  logic [31:0] rsp_data_q;
  logic        rsp_to_q;
  logic [7:0]  tx_byte;
  logic [7:0]  crc_byte;
  logic        accept;

  assign accept          = cmd.cmd_valid && ready_q;
  assign cmd.cmd_ready   = ready_q;
  assign cmd.rsp_valid   = rsp_valid_q;
  assign cmd.rsp_r1      = rsp_r1_q;
  assign cmd.rsp_data    = rsp_data_q;
  assign cmd.rsp_timeout = rsp_to_q;

`ifdef SD_CRC7_EN
  logic [6:0] crc7;
  logic       crc_en;

  // Fold each frame byte in as it is handed to the engine; byte 5 is the CRC itself.
  assign crc_en = (state == FRAME) && (phase == ISSUE) && !spi_busy && (byte_cnt < 3'd5);

  sd_crc7 u_crc7 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (crc_en),
    .din     (tx_byte),
    .crc     (crc7)
  );

  assign crc_byte = {crc7, 1'b1};
`else
  assign crc_byte = crc_lookup(idx_q);
`endif

  always_comb begin
    tx_byte = FILL_BYTE;
    if (state == FRAME) begin
      case (byte_cnt)
        3'd0:    tx_byte = {CMD_START_BITS, idx_q};
        3'd1:    tx_byte = arg_q[31:24];
        3'd2:    tx_byte = arg_q[23:16];
        3'd3:    tx_byte = arg_q[15:8];
        3'd4:    tx_byte = arg_q[7:0];
        3'd5:    tx_byte = crc_byte;
        default: tx_byte = FILL_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= ISSUE;
      byte_cnt    <= '0;
      poll_cnt    <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      long_q      <= 1'b0;
      r1_w        <= '1;
      data_w      <= '0;
      to_w        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_r1_q    <= '1;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx      <= FILL_BYTE;
      sd_cs       <= 1'b1;
    end else begin
      spi_start   <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q    <= cmd.cmd_idx;
            arg_q    <= cmd.cmd_arg;
            long_q   <= cmd.cmd_long;
            poll_cnt <= '0;
            byte_cnt <= '0;
            r1_w     <= '1;
            data_w   <= '0;
            to_w     <= 1'b0;
            phase    <= ISSUE;
            ready_q  <= 1'b0;
            state    <= PRE;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          // All remaining states share the ISSUE/WAIT byte primitive; only the
          // action taken on byte completion differs per state.
          if (phase == ISSUE) begin
            if (!spi_busy) begin
              spi_start <= 1'b1;
              spi_tx    <= tx_byte;
              phase     <= WAIT;
            end
          end else if (spi_done) begin
            phase <= ISSUE;
            case (state)
              PRE: begin
                sd_cs    <= 1'b0;
                byte_cnt <= '0;
                state    <= FRAME;
              end
              FRAME: begin
                if (byte_cnt == 3'd5) begin
                  byte_cnt <= '0;
                  state    <= POLL;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end
              POLL: begin
                if (!spi_rx[7]) begin
                  r1_w <= spi_rx;
                  if (long_q) begin
                    byte_cnt <= '0;
                    state    <= DATA;
                  end else begin
                    sd_cs <= 1'b1;
                    state <= POST;
                  end
                end else begin
                  if (poll_cnt != '1) poll_cnt <= poll_cnt + 8'd1;
                  if (poll_cnt >= NCR_LAST) begin
                    to_w  <= 1'b1;
                    r1_w  <= '1;
                    sd_cs <= 1'b1;
                    state <= POST;
                  end
                end
              end
              DATA: begin
                data_w <= {data_w[23:0], spi_rx};
                if (byte_cnt == 3'd3) begin
                  sd_cs <= 1'b1;
                  state <= POST;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end
              POST: begin
                rsp_valid_q <= 1'b1;
                rsp_r1_q    <= r1_w;
                rsp_data_q  <= data_w;
                rsp_to_q    <= to_w;
                state       <= RESP;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: scoreboard bench for sd_cmd_sequencer. Stimulus pushes
// the expected MOSI stream, the card's MISO script and the expected response;
// a card model and a response monitor pop and compare independently.
module tb_sd_cmd_sequencer;

  localparam int NCR = 8;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx;
  logic       spi_done;
  logic       spi_busy;
  logic       sd_cs;
  logic       model_busy;
  logic       force_busy;

  assign spi_busy = model_busy | force_busy;

  sd_cmd_sequencer_if bus ();

  sd_cmd_sequencer #(
    .NCR_MAX   (NCR),
    .FILL_BYTE (8'hFF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (bus),
    .spi_start (spi_start),
    .spi_tx    (spi_tx),
    .spi_rx    (spi_rx),
    .spi_done  (spi_done),
    .spi_busy  (spi_busy),
    .sd_cs     (sd_cs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       cs;
  } mosi_t;

  typedef struct packed {
    logic [7:0]  r1;
    logic [31:0] data;
    logic        to;
  } rsp_t;

  mosi_t      mosi_q[$];
  logic [7:0] rx_q[$];
  rsp_t       rsp_q[$];
  int         total = 0;
  int         bad = 0;
  int         xfer_cnt = 0;

`ifdef SD_CRC7_EN
  localparam logic [7:0] CRC55 = 8'h65;
  localparam logic [7:0] CRC58 = 8'hFD;
`else
  localparam logic [7:0] CRC55 = 8'h01;
  localparam logic [7:0] CRC58 = 8'h01;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Card / SPI engine model: checks each requested byte against the expected
  // stream, then answers from the MISO script after LAT busy cycles.
  initial begin
    model_busy = 1'b0;
    spi_done   = 1'b0;
    spi_rx     = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (spi_start) begin
        mosi_t e;
        xfer_cnt++;
        if (mosi_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mosi_extra: got %02h want no transfer", spi_tx);
        end else begin
          e = mosi_q.pop_front();
          check("mosi_byte", 32'(spi_tx), 32'(e.b));
          check("mosi_cs", 32'(sd_cs), 32'(e.cs));
        end
        model_busy = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        spi_done = 1'b1;
        spi_rx   = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
        @(posedge clk);
        #1;
        spi_done   = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // spi_start must be a single-cycle pulse raised only when busy was low.
  initial begin
    logic b;
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      b = spi_busy;
      #1;
      if (spi_start) begin
        check("start_while_busy", 32'(b), 32'd0);
        check("start_pulse_width", 32'(prev), 32'd0);
      end
      prev = spi_start;
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        rsp_t e;
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_extra: got r1=%02h want no response", bus.rsp_r1);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_r1", 32'(bus.rsp_r1), 32'(e.r1));
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
          check("ready_low_in_resp", 32'(bus.cmd_ready), 32'd0);
        end
      end
    end
  end

  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                          input logic [7:0] crc, input int nff, input logic [7:0] r1,
                          input logic [31:0] data, input logic to, input logic want_rsp);
    rsp_t       r;
    logic [7:0] b;
    mosi_q.push_back({8'hFF, 1'b1});
    mosi_q.push_back({{2'b01, idx}, 1'b0});
    mosi_q.push_back({arg[31:24], 1'b0});
    mosi_q.push_back({arg[23:16], 1'b0});
    mosi_q.push_back({arg[15:8], 1'b0});
    mosi_q.push_back({arg[7:0], 1'b0});
    mosi_q.push_back({crc, 1'b0});
    for (int i = 0; i < 7; i++) rx_q.push_back(8'hFF);
    if (to) begin
      for (int i = 0; i < NCR; i++) begin
        mosi_q.push_back({8'hFF, 1'b0});
        rx_q.push_back(8'hFF);
      end
    end else begin
      for (int i = 0; i < nff; i++) begin
        mosi_q.push_back({8'hFF, 1'b0});
        rx_q.push_back(8'hFF);
      end
      mosi_q.push_back({8'hFF, 1'b0});
      rx_q.push_back(r1);
      if (lng) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'(data >> (24 - 8 * k));
          mosi_q.push_back({8'hFF, 1'b0});
          rx_q.push_back(b);
        end
      end
    end
    mosi_q.push_back({8'hFF, 1'b1});
    rx_q.push_back(8'hFF);
    if (want_rsp) begin
      r.r1   = to ? 8'hFF : r1;
      r.data = (to || !lng) ? 32'h0 : data;
      r.to   = to;
      rsp_q.push_back(r);
    end
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                       input logic hold);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = idx;
    bus.cmd_arg   = arg;
    bus.cmd_long  = lng;
    forever begin
      @(posedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 500) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no accept want accept within 500 cycles");
        break;
      end
    end
    if (!hold) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || mosi_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("done_in_budget", 32'(n < 3000), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    check({tag, "_sd_cs"}, 32'(sd_cs), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_idx   = '0;
    bus.cmd_arg   = '0;
    bus.cmd_long  = 1'b0;
    force_busy    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_rsp_r1", 32'(bus.rsp_r1), 32'hFF);
    check("reset_rsp_data", bus.rsp_data, 32'h0);
    check("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("reset_spi_tx", 32'(spi_tx), 32'hFF);

    // CMD0, R1 after two idle polls.
    push_cmd(6'd0, 32'h0, 1'b0, 8'h95, 2, 8'h01, 32'h0, 1'b0, 1'b1);
    issue(6'd0, 32'h0, 1'b0, 1'b0);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    check("hold_rsp_r1", 32'(bus.rsp_r1), 32'h01);
    check("hold_rsp_data", bus.rsp_data, 32'h0);

    // CMD8 with R7 payload.
    push_cmd(6'd8, 32'h000001AA, 1'b1, 8'h87, 0, 8'h01, 32'h000001AA, 1'b0, 1'b1);
    issue(6'd8, 32'h000001AA, 1'b1, 1'b0);
    wait_done();

    // CMD55, card silent: timeout after NCR polls.
    push_cmd(6'd55, 32'h0, 1'b0, CRC55, 0, 8'hFF, 32'h0, 1'b1, 1'b1);
    issue(6'd55, 32'h0, 1'b0, 1'b0);
    wait_done();
    check("timeout_held", 32'(bus.rsp_timeout), 32'd1);

    // CMD58 long, card silent: payload phase skipped.
    push_cmd(6'd58, 32'h0, 1'b1, CRC58, 0, 8'hFF, 32'h0, 1'b1, 1'b1);
    issue(6'd58, 32'h0, 1'b1, 1'b0);
    wait_done();

    // Back-to-back with cmd_valid held high.
    push_cmd(6'd0, 32'h0, 1'b0, 8'h95, 0, 8'h01, 32'h0, 1'b0, 1'b1);
    push_cmd(6'd8, 32'h000001AA, 1'b1, 8'h87, 1, 8'h05, 32'hC0FF_EE12, 1'b0, 1'b1);
    issue(6'd0, 32'h0, 1'b0, 1'b1);
    issue(6'd8, 32'h000001AA, 1'b1, 1'b0);
    wait_done();

    // Reset during frame byte 3 (5th transfer): silent abort.
    push_cmd(6'd0, 32'h0, 1'b0, 8'h95, 0, 8'h01, 32'h0, 1'b0, 1'b0);
    base = xfer_cnt;
    issue(6'd0, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (xfer_cnt < base + 5 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("reach_frame_byte3", 32'(xfer_cnt >= base + 5), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    repeat (LAT + 4) @(posedge clk);
    mosi_q.delete();
    rx_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    push_cmd(6'd0, 32'h0, 1'b0, 8'h95, 0, 8'h01, 32'h0, 1'b0, 1'b1);
    issue(6'd0, 32'h0, 1'b0, 1'b0);
    wait_done();

    // Engine busy at ISSUE for 20 cycles: request withheld.
    @(negedge clk);
    force_busy = 1'b1;
    push_cmd(6'd0, 32'h0, 1'b0, 8'h95, 1, 8'h01, 32'h0, 1'b0, 1'b1);
    base = xfer_cnt;
    issue(6'd0, 32'h0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("no_start_while_busy", 32'(xfer_cnt - base), 32'd0);
    @(negedge clk);
    force_busy = 1'b0;
    wait_done();

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("mosi_queue_empty", 32'(mosi_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
